// File: rtl/mesh_term_inject_arbiter.sv
// Round-robin injector sharing one mesh terminal ingress port between NUM_SRC local
// FWFT packet queues, with a one-entry hold register and bounded per-source bursts.
module mesh_term_inject_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int PCKG_SZ   = 32,
  parameter int MAX_BURST = 2,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_SRC-1:0]           src_pndng,
  input  logic [NUM_SRC*PCKG_SZ-1:0]   src_data,
  output logic [NUM_SRC-1:0]           src_pop,
  output logic [PCKG_SZ-1:0]           term_data_out,
  output logic                         term_pndng,
  input  logic                         term_popin,
  output logic [$clog2(NUM_SRC)-1:0]   grant_idx,
  output logic                         busy,
  output logic [CNT_W-1:0]             pkt_cnt
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int BW    = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t             state_r, state_nxt_s;
  logic [IDX_W-1:0]   rr_ptr_r, grant_idx_r, winner_s, sel_idx_s, rr_nxt_s;
  logic [BW-1:0]      burst_cnt_r;
  logic [PCKG_SZ-1:0] hold_r, pop_data_s;
  logic [CNT_W-1:0]   pkt_cnt_r;
  logic               found_s, chain_s, start_s, accept_s;
  logic [NUM_SRC-1:0] src_pop_s;
  int                 idx_s;

  // Round-robin search for the first pending queue at or after rr_ptr.
  always_comb begin
    found_s  = 1'b0;
    winner_s = {IDX_W{1'b0}};
    idx_s    = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx_s = int'(rr_ptr_r) + k;
      if (idx_s >= NUM_SRC) begin
        idx_s = idx_s - NUM_SRC;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && src_pndng[idx_s]) begin
        found_s  = 1'b1;
        winner_s = IDX_W'(idx_s);
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign chain_s    = (burst_cnt_r < BW'(MAX_BURST)) && enable && src_pndng[grant_idx_r];
  assign start_s    = (state_r == IDLE) && enable && found_s;
  assign accept_s   = (state_r == OFFER) && term_popin;
  assign sel_idx_s  = (state_r == IDLE) ? winner_s : grant_idx_r;
  assign pop_data_s = src_data[sel_idx_s*PCKG_SZ +: PCKG_SZ];
  assign rr_nxt_s   = (grant_idx_r == IDX_W'(NUM_SRC - 1)) ? {IDX_W{1'b0}}
                                                            : grant_idx_r + IDX_W'(1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_nxt_s = OFFER;
        else         state_nxt_s = IDLE;
      end
      OFFER: begin
        if (accept_s && !chain_s) state_nxt_s = IDLE;
        else                      state_nxt_s = OFFER;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Pop strobe: gated by reset so no queue is drained while the block is held in reset.
  always_comb begin
    src_pop_s = {NUM_SRC{1'b0}};
    case (state_r)
      IDLE: begin
        if (start_s && !reset) src_pop_s[sel_idx_s] = 1'b1;
        else                   src_pop_s = {NUM_SRC{1'b0}};
      end
      OFFER: begin
        if (accept_s && chain_s && !reset) src_pop_s[sel_idx_s] = 1'b1;
        else                               src_pop_s = {NUM_SRC{1'b0}};
      end
      default: src_pop_s = {NUM_SRC{1'b0}};
    endcase
  end

  // Hold register, grant, burst, rotation pointer and delivery counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_r      <= {PCKG_SZ{1'b0}};
      grant_idx_r <= {IDX_W{1'b0}};
      rr_ptr_r    <= {IDX_W{1'b0}};
      burst_cnt_r <= {BW{1'b0}};
      pkt_cnt_r   <= {CNT_W{1'b0}};
    end else if (start_s) begin
      hold_r      <= pop_data_s;
      grant_idx_r <= winner_s;
      burst_cnt_r <= BW'(1);
    end else if (accept_s) begin
      pkt_cnt_r <= pkt_cnt_r + CNT_W'(1);
      if (chain_s) begin
        hold_r      <= pop_data_s;
        burst_cnt_r <= burst_cnt_r + BW'(1);
      end else begin
        rr_ptr_r    <= rr_nxt_s;
        burst_cnt_r <= {BW{1'b0}};
      end
    end else begin
      hold_r <= hold_r;
    end
  end

  assign src_pop       = src_pop_s;
  assign term_data_out = hold_r;
  assign term_pndng    = (state_r == OFFER);
  assign busy          = (state_r == OFFER);
  assign grant_idx     = grant_idx_r;
  assign pkt_cnt       = pkt_cnt_r;

endmodule

// File: tb/tb_mesh_term_inject_arbiter.sv
// Directed bench for mesh_term_inject_arbiter: small FWFT queue models feed the DUT,
// expected values are hand-derived constants checked with immediate assertions.
module tb_mesh_term_inject_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [3:0]   src_pndng;
  logic [127:0] src_data;
  logic [3:0]   src_pop;
  logic [31:0]  term_data_out;
  logic         term_pndng;
  logic         term_popin;
  logic [1:0]   grant_idx;
  logic         busy;
  logic [15:0]  pkt_cnt;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [31:0] qmem [4][16];
  int          qhead [4];
  int          qtail [4];
  int          kcnt  [4];
  logic [3:0]  pop_v;

  mesh_term_inject_arbiter #(.NUM_SRC(4), .PCKG_SZ(32), .MAX_BURST(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .src_pndng(src_pndng), .src_data(src_data),
    .src_pop(src_pop), .term_data_out(term_data_out), .term_pndng(term_pndng),
    .term_popin(term_popin), .grant_idx(grant_idx), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < 4; i++) begin
      src_pndng[i] = (qhead[i] < qtail[i]);
      src_data[i*32 +: 32] = (qhead[i] < 16) ? qmem[i][qhead[i]] : 32'h0;
    end
  endtask

  task automatic push(input int q, input logic [31:0] w);
    qmem[q][qtail[q]] = w;
    qtail[q]++;
    drive_srcs();
  endtask

  task automatic flush(input int q);
    qhead[q] = qtail[q];
    drive_srcs();
  endtask

  // Advance one clock; queues popped by the DUT this cycle advance their head.
  task automatic tick();
    #1;
    pop_v = src_pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (pop_v[i]) qhead[i]++;
    drive_srcs();
    #1;
  endtask

  initial begin
    int s;
    reset = 1'b1; enable = 1'b1; term_popin = 1'b1;
    src_pndng = 4'b0; src_data = 128'b0;
    for (int i = 0; i < 4; i++) begin
      qhead[i] = 0; qtail[i] = 0; kcnt[i] = 0;
      for (int k = 0; k < 4; k++) push(i, 32'h1000_0000 * (i + 1) + k);
    end
    repeat (3) tick();
    check("rst_pop", src_pop, 4'b0000);
    check("rst_pndng", term_pndng, 1'b0);
    check("rst_cnt", pkt_cnt, 16'd0);
    check("rst_grant", grant_idx, 2'd0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0; #1;
    check("first_pop", src_pop, 4'b0001);

    // Fairness: all queues full, two packets per source, one bubble between sources
    for (int n = 0; n < 10; n++) begin
      s = (n / 2) % 4;
      if (n % 2 == 0) begin
        check("fair_bubble", busy, 1'b0);
        check("fair_pop", src_pop, 4'b0001 << s);
        tick();
      end
      check("fair_pndng", term_pndng, 1'b1);
      check("fair_grant", grant_idx, s);
      check("fair_data", term_data_out, 32'h1000_0000 * (s + 1) + kcnt[s]);
      kcnt[s]++;
      if (n == 9) begin
        for (int i = 0; i < 4; i++) flush(i);
        #1;
      end
      tick();
    end
    check("fair_cnt", pkt_cnt, 16'd10);
    check("fair_idle", busy, 1'b0);
    check("fair_nopop", src_pop, 4'b0000);

    // Single source, rr_ptr is now 1
    push(2, 32'hA000_0001); push(2, 32'hA000_0002); #1;
    check("ss_pop0", src_pop, 4'b0100);
    tick();
    check("ss_data0", term_data_out, 32'hA000_0001);
    check("ss_pop1", src_pop, 4'b0100);
    tick();
    check("ss_data1", term_data_out, 32'hA000_0002);
    check("ss_pop2", src_pop, 4'b0000);
    tick();
    check("ss_idle", busy, 1'b0);
    check("ss_cnt", pkt_cnt, 16'd12);

    // Backpressure; rr_ptr=3 so the search wraps to queue 0
    term_popin = 1'b0;
    push(0, 32'h1234_5678); #1;
    check("bp_pop", src_pop, 4'b0001);
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_data", term_data_out, 32'h1234_5678);
      check("bp_pndng", term_pndng, 1'b1);
      check("bp_nopop", src_pop, 4'b0000);
      tick();
    end
    check("bp_cnt_hold", pkt_cnt, 16'd12);
    term_popin = 1'b1; #1;
    check("bp_last_nopop", src_pop, 4'b0000);
    tick();
    check("bp_cnt", pkt_cnt, 16'd13);
    check("bp_idle", busy, 1'b0);

    // enable drop during OFFER; rr_ptr=1
    push(1, 32'hB000_0001); push(1, 32'hB000_0002); push(1, 32'hB000_0003); #1;
    check("en_pop", src_pop, 4'b0010);
    tick();
    enable = 1'b0; term_popin = 1'b0; #1;
    check("en_pndng", term_pndng, 1'b1);
    check("en_data", term_data_out, 32'hB000_0001);
    check("en_nopop0", src_pop, 4'b0000);
    tick();
    term_popin = 1'b1; #1;
    check("en_nochain", src_pop, 4'b0000);
    tick();
    check("en_cnt", pkt_cnt, 16'd14);
    check("en_idle", busy, 1'b0);
    check("en_nopop1", src_pop, 4'b0000);
    tick();
    check("en_nopop2", src_pop, 4'b0000);
    push(3, 32'hC000_0001); enable = 1'b1; #1;
    check("en_resume_pop", src_pop, 4'b1000);
    tick();
    check("en_resume_grant", grant_idx, 2'd3);
    check("en_resume_data", term_data_out, 32'hC000_0001);

    // Async reset mid-OFFER
    push(0, 32'hD000_0001); #1;
    reset = 1'b1; #1;
    check("ar_pndng", term_pndng, 1'b0);
    check("ar_cnt", pkt_cnt, 16'd0);
    check("ar_pop", src_pop, 4'b0000);
    check("ar_grant", grant_idx, 2'd0);
    tick();
    reset = 1'b0; #1;
    check("ar_restart_pop", src_pop, 4'b0001);
    tick();
    check("ar_restart_grant", grant_idx, 2'd0);
    check("ar_restart_data", term_data_out, 32'hD000_0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mesh_term_inject_arbiter.md
Name: mesh_term_inject_arbiter

Overview:
- Round-robin scheduler that shares one mesh terminal ingress port (router side: data_out_i_in / pndng_i_in / popin) between NUM_SRC local first-word-fall-through packet queues.
- Pops the winning queue, holds the packet in a one-entry register and offers it to the router until popin.
- Limits each grant to MAX_BURST consecutive packets before rotating.
- Instantiated per terminal between the local agents' FIFOs and mesh_gnrtr.

Parameters:
- NUM_SRC, 4, number of requesting local queues (>=2).
- PCKG_SZ, 32, packet width in bits; matches the router pckg_sz.
- MAX_BURST, 2, max consecutive packets granted to one source per turn (>=1).
- CNT_W, 16, width of the delivered-packet counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = new pops allowed.
- src_pndng  in  NUM_SRC  bit i: queue i non-empty.
- src_data  in  NUM_SRC*PCKG_SZ  head word of queue i at bits [i*PCKG_SZ +: PCKG_SZ].
- src_pop  out  NUM_SRC  one-cycle pop strobe to queue i; one-hot or zero.
- term_data_out  out  PCKG_SZ  packet offered to router (to data_out_i_in).
- term_pndng  out  1  offered packet valid (to pndng_i_in).
- term_popin  in  1  router accepts the offered packet this cycle.
- grant_idx  out  $clog2(NUM_SRC)  source of the packet currently or last held.
- busy  out  1  1 while in OFFER.
- pkt_cnt  out  CNT_W  total packets accepted by router; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, active-high): all outputs 0, rr_ptr=0, burst_cnt=0, hold=0, state=IDLE. Asserting reset mid-OFFER drops term_pndng immediately; the held packet is discarded. The source was already popped, so that packet is lost by design.
- States: IDLE, OFFER.
- IDLE, enable=1 and |src_pndng:
  - winner = first i with src_pndng[i] searching rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - src_pop[winner]=1 combinationally this cycle.
  - At the edge: hold <= src_data[winner], grant_idx <= winner, burst_cnt <= 1, state <= OFFER.
- IDLE otherwise: no pop, stay.
- OFFER: term_pndng=1, term_data_out=hold, busy=1; hold is stable until term_popin=1.
- OFFER with term_popin=1 (acceptance edge): pkt_cnt++.
  - Chain condition: burst_cnt<MAX_BURST, enable=1 and src_pndng[grant_idx]=1.
  - If the chain condition holds: src_pop[grant_idx]=1 same cycle, hold reloads, burst_cnt++, stay OFFER. This gives back-to-back delivery at 1 packet/cycle.
  - Otherwise: rr_ptr <= grant_idx+1 mod NUM_SRC, burst_cnt <= 0, state <= IDLE.
- Latency: pop to term_pndng = 1 cycle. Source switch costs one IDLE bubble cycle.
- OFFER with term_popin=0: hold, no pops. Backpressure is unbounded.
- enable deassert during OFFER: the held packet is still offered until accepted; no further pops; return to IDLE.
- term_popin while IDLE: ignored.
- A source's pndng dropping while it is not popped has no effect.
- src_pop is never asserted for a queue with src_pndng=0. Never more than one src_pop bit is set.
- No starvation: any pending source is granted within NUM_SRC-1 turns.
- Packet contents are not inspected, including broadcast ID and row/column fields.

Test Plan:
(All with NUM_SRC=4, PCKG_SZ=32, MAX_BURST=2, popin tied 1 unless stated.)
- Reset: hold reset 3 cycles with all src_pndng=1 -> src_pop=0, term_pndng=0, pkt_cnt=0, grant_idx=0. Release -> first pop is src_pop=4'b0001.
- Single source: queue 2 holds 0xA000_0001, 0xA000_0002.
  - Cycle t: src_pop=4'b0100.
  - t+1: term_data_out=0xA000_0001, second pop in the same cycle.
  - t+2: term_data_out=0xA000_0002.
  - t+3: IDLE, pkt_cnt=2, rr_ptr=3.
- Fairness: all four queues stay full -> grant_idx sequence 0,0,1,1,2,2,3,3,0,0 with one bubble between sources; pkt_cnt=10 after 10 acceptances.
- Backpressure: popin held 0 for 5 cycles while offering 0x1234_5678 -> term_data_out stable at 0x1234_5678, term_pndng=1, src_pop=0 throughout. popin=1 -> pkt_cnt+1.
- enable drop: deassert enable during OFFER -> held packet still delivered on popin, then no src_pop while enable=0. Re-enable -> resumes from rr_ptr.
- Async reset mid-OFFER: assert reset between edges -> term_pndng falls before the next edge, pkt_cnt=0. After release, arbitration restarts from source 0.
